// File: rtl/data_bus_pkg.sv
// Shared types and constants for the two-master data bus arbiter.
package data_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   // Arbiter FSM: wait for a request, run the bus phase, pulse the ack
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      ACK  = 2'd2
   } state_e;

   // Owner encoding used on the owner output and internally
   localparam logic OWNER_M0 = 1'b0;
   localparam logic OWNER_M1 = 1'b1;

endpackage

// File: rtl/data_bus_arb_pick.sv
// Combinational grant decision between CPU (M0) and DMA (M1) masters:
// round-robin on contention, with an M1 lock that is bounded by MAX_BURST.
module data_bus_arb_pick
   import data_bus_pkg::*;
#(
   parameter int MAX_BURST = 8
) (
   input  logic       m0_req,
   input  logic       m1_req,
   input  logic       m1_lock,
   input  logic       last_owner,
   input  logic [7:0] burst_cnt,
   output logic       grant_valid,
   output logic       grant_owner
);

   localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

   // Pick the winner; the lock only extends an M1 run that is already in progress
   always_comb begin
      grant_valid = m0_req | m1_req;
      grant_owner = OWNER_M0;
      if (m0_req && m1_req) begin
         if ((last_owner == OWNER_M1) && m1_lock && (burst_cnt < BURST_MAX)) begin
            grant_owner = OWNER_M1;
         end else begin
            grant_owner = ~last_owner;
         end
      end else if (m1_req) begin
         grant_owner = OWNER_M1;
      end
   end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter: serialises M0/M1 transactions onto the shared
// bus with a fixed-length bus phase and a one-cycle completion ack.
module data_bus_arbiter
   import data_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int MAX_BURST   = 8
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [BE_W-1:0]   m0_be,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [BE_W-1:0]   m1_be,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m1_lock,
   output logic              m0_ack,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] DAddress,
   output logic [DATA_W-1:0] DWriteData,
   output logic [BE_W-1:0]   DByteEnable,
   output logic              DReadEnable,
   output logic              DWriteEnable,
   input  logic [DATA_W-1:0] DReadData,
   output logic              owner,
   output logic              busy
);

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
   localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

   state_e              state_q;
   logic [3:0]          wait_q;
   logic                owner_q;
   logic                last_owner_q;
   logic [7:0]          burst_cnt_q;
   logic [7:0]          burst_cnt_d;
   logic                lat_we_q;
   logic [ADDR_W-1:0]   daddr_q;
   logic [DATA_W-1:0]   dwdata_q;
   logic [BE_W-1:0]     dbe_q;
   logic                dre_q;
   logic                dwe_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                m0_ack_q;
   logic                m1_ack_q;
   logic                busy_q;

   logic                grant_valid;
   logic                grant_owner;
   logic                sel_we;
   logic [BE_W-1:0]     sel_be;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   data_bus_arb_pick #(
      .MAX_BURST (MAX_BURST)
   ) u_pick (
      .m0_req      (m0_req),
      .m1_req      (m1_req),
      .m1_lock     (m1_lock),
      .last_owner  (last_owner_q),
      .burst_cnt   (burst_cnt_q),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   // Payload of the winning master and the burst count after this grant
   always_comb begin
      sel_we      = m0_we;
      sel_be      = m0_be;
      sel_addr    = m0_addr;
      sel_wdata   = m0_wdata;
      burst_cnt_d = 8'd0;
      if (grant_owner == OWNER_M1) begin
         sel_we      = m1_we;
         sel_be      = m1_be;
         sel_addr    = m1_addr;
         sel_wdata   = m1_wdata;
         burst_cnt_d = burst_cnt_q;
         if (m0_req && (burst_cnt_q < BURST_MAX)) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
         end
      end
   end

   // Arbiter FSM; all bus-facing outputs are registered and only nonzero in BUS
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q      <= IDLE;
         wait_q       <= 4'd0;
         owner_q      <= OWNER_M0;
         last_owner_q <= OWNER_M1;
         burst_cnt_q  <= 8'd0;
         lat_we_q     <= 1'b0;
         daddr_q      <= '0;
         dwdata_q     <= '0;
         dbe_q        <= '0;
         dre_q        <= 1'b0;
         dwe_q        <= 1'b0;
         rdata_q      <= '0;
         m0_ack_q     <= 1'b0;
         m1_ack_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  state_q      <= BUS;
                  wait_q       <= WAIT_LOAD;
                  owner_q      <= grant_owner;
                  last_owner_q <= grant_owner;
                  burst_cnt_q  <= burst_cnt_d;
                  lat_we_q     <= sel_we;
                  daddr_q      <= sel_addr;
                  dwdata_q     <= sel_wdata;
                  dbe_q        <= sel_be;
                  dre_q        <= ~sel_we;
                  // Write strobe only in the last bus cycle (single pulse)
                  dwe_q        <= sel_we && (WAIT_LOAD == 4'd0);
                  busy_q       <= 1'b1;
               end
            end
            BUS: begin
               if (wait_q == 4'd0) begin
                  state_q  <= ACK;
                  daddr_q  <= '0;
                  dwdata_q <= '0;
                  dbe_q    <= '0;
                  dre_q    <= 1'b0;
                  dwe_q    <= 1'b0;
                  m0_ack_q <= (owner_q == OWNER_M0);
                  m1_ack_q <= (owner_q == OWNER_M1);
                  if (!lat_we_q) begin
                     rdata_q <= DReadData;
                  end
               end else begin
                  wait_q <= wait_q - 4'd1;
                  dwe_q  <= lat_we_q && (wait_q == 4'd1);
               end
            end
            ACK: begin
               state_q  <= IDLE;
               m0_ack_q <= 1'b0;
               m1_ack_q <= 1'b0;
               busy_q   <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign m0_ack       = m0_ack_q;
   assign m1_ack       = m1_ack_q;
   assign m0_rdata     = rdata_q;
   assign m1_rdata     = rdata_q;
   assign DAddress     = daddr_q;
   assign DWriteData   = dwdata_q;
   assign DByteEnable  = dbe_q;
   assign DReadEnable  = dre_q;
   assign DWriteEnable = dwe_q;
   assign owner        = owner_q;
   assign busy         = busy_q;

endmodule
